// File: rtl/endian_swap_queue.sv
// Endian swap queue: byte-group reversal / lane masking of store-load data,
// buffered in a FIFO with valid/busy handshakes on both sides.
module endian_swap_queue #(
    parameter int P_LANES = 4,
    parameter int P_DEPTH = 2
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iFLUSH,
    input  logic                 iSRC_VALID,
    output logic                 oSRC_BUSY,
    input  logic                 iSRC_MODE,
    input  logic [P_LANES-1:0]   iSRC_MASK,
    input  logic [8*P_LANES-1:0] iSRC_DATA,
    output logic                 oDEST_VALID,
    input  logic                 iDEST_BUSY,
    output logic [P_LANES-1:0]   oDEST_MASK,
    output logic [8*P_LANES-1:0] oDEST_DATA,
    output logic                 oDEST_ERROR,
    output logic [7:0]           oERR_COUNT
);

    localparam int W  = 8 * P_LANES;
    localparam int LW = $clog2(P_LANES);
    localparam int PW = $clog2(P_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = W + P_LANES + 1;

    logic          legal;
    logic [LW-1:0] span;
    logic [W-1:0]  conv_data;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    logic [EW-1:0] mem [P_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [7:0]    err_cnt;
    logic          push;
    logic          pop;

    // Find the aligned power-of-two run that matches the mask, if any.
    // span is the group size minus one, used as an XOR lane mirror.
    always_comb begin
        legal = 1'b0;
        span  = '0;
        for (int s = 0; s <= LW; s++) begin
            for (int k = 0; k < P_LANES; k++) begin
                if ((k % (1 << s)) == 0 &&
                    iSRC_MASK == P_LANES'(((1 << (1 << s)) - 1) << k)) begin
                    legal = 1'b1;
                    span  = LW'((1 << s) - 1);
                end
            end
        end
    end

    // Within an aligned group, lane k+j mirrors to k+n-1-j, which is
    // the lane index XOR (n-1) because k has no bits below n.
    for (genvar g = 0; g < P_LANES; g++) begin : g_lane
        logic [LW-1:0] src;
        assign src = LW'(g) ^ (iSRC_MODE ? span : '0);
        assign conv_data[8*g +: 8] =
            (legal && iSRC_MASK[g]) ? iSRC_DATA[8*src +: 8] : 8'h00;
    end

    assign entry = {~legal, iSRC_MASK, conv_data};

    assign oSRC_BUSY   = (count == CW'(P_DEPTH));
    assign oDEST_VALID = (count != '0);

    assign push = iSRC_VALID && !oSRC_BUSY && !iFLUSH;
    assign pop  = oDEST_VALID && !iDEST_BUSY && !iFLUSH;

    assign head        = mem[rd_ptr];
    assign oDEST_DATA  = oDEST_VALID ? head[W-1:0] : '0;
    assign oDEST_MASK  = oDEST_VALID ? head[W +: P_LANES] : '0;
    assign oDEST_ERROR = oDEST_VALID && head[EW-1];
    assign oERR_COUNT  = err_cnt;

    // Storage array; reads are masked by oDEST_VALID so no reset needed.
    always_ff @(posedge iCLOCK) begin
        if (push) begin
            mem[wr_ptr] <= entry;
        end
    end

    // Pointer and occupancy tracking; flush wins over push and pop.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (iFLUSH) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturating count of accepted illegal masks; survives flush.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            err_cnt <= '0;
        end else if (push && !legal && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_endian_swap_queue.sv
// Bench for endian_swap_queue: directed plan steps plus random traffic
// against a queue-based reference model.
module tb_endian_swap_queue;

    localparam int DEPTH  = 2;
    localparam int DEPTH8 = 4;

    typedef struct {
        logic [15:0]  m;
        logic [127:0] d;
        logic         e;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, sv, mode, dbusy;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        sbusy, dvalid, derr;
    logic [3:0]  dmask;
    logic [31:0] ddata;
    logic [7:0]  ecnt;

    logic        flush8, sv8, mode8, dbusy8;
    logic [7:0]  mask8;
    logic [63:0] data8;
    logic        sbusy8, dvalid8, derr8;
    logic [7:0]  dmask8;
    logic [63:0] ddata8;
    logic [7:0]  ecnt8;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t q[$];
    int   ecnt_m = 0;

    always #5 clk = ~clk;

    endian_swap_queue #(.P_LANES(4), .P_DEPTH(DEPTH)) u4 (
        .iCLOCK(clk), .inRESET(rst_n), .iFLUSH(flush),
        .iSRC_VALID(sv), .oSRC_BUSY(sbusy), .iSRC_MODE(mode),
        .iSRC_MASK(mask), .iSRC_DATA(data),
        .oDEST_VALID(dvalid), .iDEST_BUSY(dbusy),
        .oDEST_MASK(dmask), .oDEST_DATA(ddata),
        .oDEST_ERROR(derr), .oERR_COUNT(ecnt)
    );

    endian_swap_queue #(.P_LANES(8), .P_DEPTH(DEPTH8)) u8 (
        .iCLOCK(clk), .inRESET(rst_n), .iFLUSH(flush8),
        .iSRC_VALID(sv8), .oSRC_BUSY(sbusy8), .iSRC_MODE(mode8),
        .iSRC_MASK(mask8), .iSRC_DATA(data8),
        .oDEST_VALID(dvalid8), .iDEST_BUSY(dbusy8),
        .oDEST_MASK(dmask8), .oDEST_DATA(ddata8),
        .oDEST_ERROR(derr8), .oERR_COUNT(ecnt8)
    );

    // Reference conversion from the mask rules: popcount n, lowest lane k.
    function automatic void ref_conv(input int lanes, input logic [15:0] m,
                                     input logic [127:0] d, input logic md,
                                     output logic [127:0] o, output logic e);
        int n;
        int k;
        logic [31:0] run;
        o = '0;
        e = 1'b1;
        n = $countones(m);
        k = 0;
        for (int i = lanes - 1; i >= 0; i--) if (m[i]) k = i;
        run = ((32'd1 << n) - 32'd1) << k;
        if (n == 0 || (n & (n - 1)) != 0 || (k % n) != 0 ||
            {16'b0, m} != run) return;
        e = 1'b0;
        for (int j = 0; j < n; j++) begin
            if (md) o[8*(k+j) +: 8] = d[8*(k+n-1-j) +: 8];
            else    o[8*(k+j) +: 8] = d[8*(k+j) +: 8];
        end
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("valid", 128'(dvalid), 128'(q.size() > 0));
        chk("src_busy", 128'(sbusy), 128'(q.size() == DEPTH));
        chk("err_count", 128'(ecnt), 128'(ecnt_m));
        if (q.size() > 0) begin
            chk("mask", 128'(dmask), 128'(q[0].m));
            chk("data", 128'(ddata), q[0].d);
            chk("error", 128'(derr), 128'(q[0].e));
        end else begin
            chk("mask_idle", 128'(dmask), 128'(0));
            chk("data_idle", 128'(ddata), 128'(0));
            chk("error_idle", 128'(derr), 128'(0));
        end
    endtask

    // One clock of the 4-lane DUT with model update and full output check.
    task automatic cyc(input logic v, input logic md, input logic [3:0] m,
                       input logic [31:0] d, input logic b, input logic f);
        logic         acc;
        logic         pp;
        logic [127:0] o;
        logic         e;
        ent_t         en;
        sv = v; mode = md; mask = m; data = d; dbusy = b; flush = f;
        acc = v && (q.size() < DEPTH);
        pp  = (q.size() > 0) && !b;
        ref_conv(4, {12'b0, m}, {96'b0, d}, md, o, e);
        en.m = {12'b0, m};
        en.d = o;
        en.e = e;
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(en);
                if (e && ecnt_m < 255) ecnt_m++;
            end
        end
        check_out();
    endtask

    logic [3:0] legal4 [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    initial begin
        logic [127:0] o;
        logic         e;
        logic [3:0]   rm;
        rst_n = 1'b0;
        flush = 0; sv = 0; mode = 0; mask = 0; data = 0; dbusy = 0;
        flush8 = 0; sv8 = 0; mode8 = 0; mask8 = 0; data8 = 0; dbusy8 = 0;
        #3;
        chk("rst_valid", 128'(dvalid), 128'(0));
        chk("rst_busy", 128'(sbusy), 128'(0));
        chk("rst_data", 128'(ddata), 128'(0));
        chk("rst_ecnt", 128'(ecnt), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(1, 1, 4'hF, 32'h11223344, 0, 0);
        chk("be_full", 128'(ddata), 128'(32'h44332211));
        chk("be_full_valid", 128'(dvalid), 128'(1));
        cyc(1, 1, 4'b1100, 32'hAABBCCDD, 0, 0);
        chk("be_hi2", 128'(ddata), 128'(32'hBBAA0000));
        cyc(1, 1, 4'b0011, 32'hAABBCCDD, 0, 0);
        chk("be_lo2", 128'(ddata), 128'(32'h0000DDCC));
        cyc(1, 1, 4'b0100, 32'hAABBCCDD, 0, 0);
        chk("be_one", 128'(ddata), 128'(32'h00BB0000));
        cyc(1, 0, 4'b0011, 32'hAABBCCDD, 0, 0);
        chk("le_lo2", 128'(ddata), 128'(32'h0000CCDD));

        cyc(1, 1, 4'b0101, 32'hAABBCCDD, 0, 0);
        chk("ill_5_err", 128'(derr), 128'(1));
        chk("ill_5_mask", 128'(dmask), 128'(4'b0101));
        cyc(1, 1, 4'b0110, 32'hAABBCCDD, 0, 0);
        chk("ill_6_data", 128'(ddata), 128'(0));
        cyc(1, 0, 4'b0000, 32'hAABBCCDD, 0, 0);
        chk("ill_0_err", 128'(derr), 128'(1));
        chk("ecnt_3", 128'(ecnt), 128'(3));
        cyc(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) cyc(1, 1, 4'b1001, $urandom, 0, 0);
        chk("ecnt_sat", 128'(ecnt), 128'(255));
        cyc(0, 0, 0, 0, 0, 0);

        cyc(1, 1, 4'hF, 32'h01020304, 1, 0);
        cyc(1, 1, 4'hF, 32'h05060708, 1, 0);
        chk("full_busy", 128'(sbusy), 128'(1));
        cyc(1, 1, 4'hF, 32'h090A0B0C, 1, 0);
        chk("held_busy", 128'(sbusy), 128'(1));
        chk("held_head", 128'(ddata), 128'(32'h04030201));
        cyc(1, 1, 4'hF, 32'h090A0B0C, 0, 0);
        chk("ord_b", 128'(ddata), 128'(32'h08070605));
        chk("busy_fall", 128'(sbusy), 128'(0));
        cyc(1, 1, 4'hF, 32'h090A0B0C, 0, 0);
        chk("ord_c", 128'(ddata), 128'(32'h0C0B0A09));
        cyc(0, 0, 0, 0, 0, 0);
        chk("ord_empty", 128'(dvalid), 128'(0));

        cyc(1, 0, 4'hF, $urandom, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 4'hF, $urandom, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            rm = ($urandom % 2 == 0) ? legal4[$urandom % 7] : 4'($urandom);
            cyc(($urandom % 4) != 0, 1'($urandom), rm, $urandom,
                ($urandom % 3) == 0, ($urandom % 25) == 0);
        end
        cyc(0, 0, 0, 0, 0, 1);

        sv8 = 1; mode8 = 1; mask8 = 8'hF0; data8 = 64'h0011223344556677;
        dbusy8 = 1;
        @(posedge clk);
        #1;
        chk("l8_valid", 128'(dvalid8), 128'(1));
        chk("l8_data", 128'(ddata8), 128'(64'h3322110000000000));
        ref_conv(8, 16'h00F0, {64'b0, 64'h0011223344556677}, 1'b1, o, e);
        chk("l8_model", 128'(ddata8), o);
        chk("l8_mask", 128'(dmask8), 128'(8'hF0));
        mask8 = 8'h0F; data8 = 64'h8899AABBCCDDEEFF;
        @(posedge clk);
        #1;
        chk("l8_stable", 128'(ddata8), 128'(64'h3322110000000000));
        flush8 = 1; mask8 = 8'h07;
        @(posedge clk);
        #1;
        flush8 = 0; sv8 = 0;
        chk("flush_valid", 128'(dvalid8), 128'(0));
        chk("flush_data", 128'(ddata8), 128'(0));
        chk("flush_ecnt", 128'(ecnt8), 128'(0));
        sv8 = 1; mask8 = 8'hF0; data8 = 64'h0011223344556677;
        cyc(1, 1, 4'hF, 32'h11223344, 1, 0);
        sv8 = 0;
        chk("pre_rst_valid8", 128'(dvalid8), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(dvalid), 128'(0));
        chk("mid_rst_data", 128'(ddata), 128'(0));
        chk("mid_rst_mask", 128'(dmask), 128'(0));
        chk("mid_rst_err", 128'(derr), 128'(0));
        chk("mid_rst_ecnt", 128'(ecnt), 128'(0));
        chk("mid_rst_valid8", 128'(dvalid8), 128'(0));
        chk("mid_rst_data8", 128'(ddata8), 128'(0));
        chk("mid_rst_busy8", 128'(sbusy8), 128'(0));
        chk("mid_rst_err8", 128'(derr8), 128'(0));
        chk("mid_rst_mask8", 128'(dmask8), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/endian_swap_queue.md
# endian_swap_queue

Parametrised, buffered successor to the memory-port endian controller. It accepts byte-masked store/load data plus a per-transfer endian mode and applies an in-place byte reversal of the masked group in big-endian mode, or lane masking in little-endian mode. It flags and counts illegal masks, and queues results in a FIFO with valid/busy handshakes on both sides. It sits between the load/store unit and the memory bus interface.

## Interface
- P_LANES, 4: byte lanes; power of 2, 2..16; data width = 8*P_LANES.
- P_DEPTH, 2: FIFO entries; power of 2, >= 2.
- iCLOCK  in  1  clock; all state on rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iFLUSH  in  1  synchronous flush of FIFO contents.
- iSRC_VALID  in  1  source request.
- oSRC_BUSY  out  1  FIFO full; source must hold.
- iSRC_MODE  in  1  1 = big-endian (reverse group), 0 = little-endian (pass).
- iSRC_MASK  in  P_LANES  byte-lane mask.
- iSRC_DATA  in  8*P_LANES  lane data; lane k = bits [8k+7:8k].
- oDEST_VALID  out  1  head entry valid.
- iDEST_BUSY  in  1  sink stall.
- oDEST_MASK  out  P_LANES  mask of head entry, equal to the source mask.
- oDEST_DATA  out  8*P_LANES  converted data of head entry.
- oDEST_ERROR  out  1  head entry had an illegal mask.
- oERR_COUNT  out  8  saturating illegal-mask counter.

## Operation
- Source accept: iSRC_VALID && !oSRC_BUSY. Sink pop: oDEST_VALID && !iDEST_BUSY.
- Legal mask: contiguous run of n = 1, 2, 4, …, P_LANES set bits starting at lane k, where k is a multiple of n. Any other mask, including all zero, is illegal.
- Big-endian mode with a legal mask: output lane k+j = input lane k+n-1-j for j = 0..n-1; all other lanes are 0.
- Little-endian mode with a legal mask: output lane = input lane where the mask bit is 1, else 0.
- Illegal mask, either mode: data = 0, error = 1, mask passed through unchanged.
- Conversion is combinational on the source side. The entry {mask, data, error} is written into the FIFO on accept.
- oSRC_BUSY = (count == P_DEPTH). Accept never occurs when full, so no push-through exists.
- Push and pop in the same cycle: count unchanged, and order is preserved (strict FIFO).
- oERR_COUNT increments on each accepted illegal entry and saturates at 255. It is cleared only by reset; iFLUSH does not clear it.
- iFLUSH: count, read pointer and write pointer go to 0 at the next edge. Any push or pop in that cycle is discarded, and the error counter is not incremented for a discarded push.

## Timing
- Reset (inRESET low, asynchronous): oDEST_VALID=0, oSRC_BUSY=0, oDEST_MASK=0, oDEST_DATA=0, oDEST_ERROR=0, oERR_COUNT=0, pointers and count = 0.
- Latency: an entry accepted at edge N is visible with oDEST_VALID=1 after edge N (usable in cycle N+1) if the FIFO was empty.
- Throughput: 1 entry/cycle when iDEST_BUSY=0.
- oDEST_* are stable while oDEST_VALID && iDEST_BUSY.
- oDEST_MASK, oDEST_DATA and oDEST_ERROR are driven to 0 whenever oDEST_VALID=0.
- oSRC_BUSY rises after the edge that fills the last entry and falls after the edge of the first pop from full. It has no combinational path from iDEST_BUSY.
- Pointers wrap modulo P_DEPTH.

## Test plan
- Lanes=4, mode=1, mask=4'hF, data 32'h11223344 -> oDEST_DATA=32'h44332211, mask F, error 0; oDEST_VALID 1 cycle after accept.
- Lanes=4, mode=1, data 32'hAABBCCDD: mask 4'b1100 -> 32'hBBAA0000; 4'b0011 -> 32'h0000DDCC; 4'b0100 -> 32'h00BB0000. Mode=0, mask 4'b0011 -> 32'h0000CCDD.
- Illegal masks 4'b0101, 4'b0110, 4'b0000 -> data 0, error 1, mask unchanged, oERR_COUNT 0->3. Push 300 illegal entries -> oERR_COUNT holds at 255.
- Depth=2, iDEST_BUSY=1, push A, B, C -> oSRC_BUSY=1 after B and C held. Release busy -> outputs A, B, C in order, with C accepted the cycle after the first pop.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1 and no entry is lost or duplicated.
- Lanes=8, mode=1, mask 8'hF0, data 64'h0011223344556677 -> 64'h3322110000000000. Then assert iFLUSH with 2 entries queued -> oDEST_VALID=0 next cycle. Then drop inRESET mid-stream -> all outputs 0 immediately.
